// File: rtl/mem_pkg.sv
// mem_pkg: shared ls_op field positions, access-size encodings and stage FSM states
package mem_pkg;
  localparam int OP_LOAD  = 4;
  localparam int OP_STORE = 3;
  localparam int OP_SIGN  = 2;
  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;
  localparam logic [1:0] SIZE_D = 2'd3;
  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;
endpackage

// File: rtl/lsu_align.sv
// lsu_align: misalignment check, store lane placement and load extraction/extension
module lsu_align
  import mem_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [$clog2(DATA_W/8)-1:0] off,
  input  logic [1:0]                  size,
  input  logic                        sign,
  input  logic [DATA_W-1:0]           store_data,
  input  logic [DATA_W-1:0]           rdata,
  output logic                        misaligned,
  output logic [DATA_W/8-1:0]         wen,
  output logic [DATA_W-1:0]           wdata,
  output logic [DATA_W-1:0]           load_data
);
  localparam int NB = DATA_W / 8;
  logic [NB-1:0] ones;
  logic [DATA_W-1:0] sh, keep;
  logic sbit;
  always_comb begin
    misaligned = (size == SIZE_D && DATA_W == 32) || ((32'(off) & ((32'd1 << size) - 32'd1)) != 32'd0);
    ones = size == SIZE_B ? NB'(1) : size == SIZE_H ? NB'(3) : size == SIZE_W ? NB'(15) : '1;
    wen = ones << off;
    // replicate the low 2^size bytes of the operand into every lane
    for (int i = 0; i < NB; i++) wdata[8*i +: 8] = store_data[8*(i % (1 << size)) +: 8];
    sh = rdata >> {off, 3'b000};
    keep = size == SIZE_B ? DATA_W'(32'hFF) : size == SIZE_H ? DATA_W'(32'hFFFF) :
           size == SIZE_W ? DATA_W'(32'hFFFF_FFFF) : '1;
    sbit = sign & (size == SIZE_B ? sh[7] : size == SIZE_H ? sh[15] : size == SIZE_W ? sh[31] : sh[DATA_W-1]);
    load_data = (sh & keep) | ({DATA_W{sbit}} & ~keep);
  end
endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: EXE->WB memory stage talking to variable-latency memory via req/gnt/rvalid
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int WDEST_W = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                mem_valid,
  input  logic                mem_allow_in,
  input  logic [4:0]          ls_op,
  input  logic [ADDR_W-1:0]   ls_addr,
  input  logic [DATA_W-1:0]   store_data,
  input  logic [DATA_W-1:0]   exe_result,
  input  logic [WDEST_W-1:0]  rf_wdest,
  output logic                dm_req,
  output logic [DATA_W/8-1:0] dm_wen,
  output logic [ADDR_W-1:0]   dm_addr,
  output logic [DATA_W-1:0]   dm_wdata,
  input  logic                dm_gnt,
  input  logic                dm_rvalid,
  input  logic [DATA_W-1:0]   dm_rdata,
  output logic                mem_over,
  output logic [DATA_W-1:0]   mem_result,
  output logic [WDEST_W-1:0]  mem_wdest,
  output logic                mem_ade
);
  localparam int NB = DATA_W / 8;
  localparam int OW = $clog2(NB);
  state_t state, next;
  logic load, store, mem_op, misaligned;
  logic [NB-1:0] wen;
  logic [DATA_W-1:0] wdata, load_data, res_q;
  assign load = ls_op[OP_LOAD];
  assign store = ls_op[OP_STORE] & ~load;
  assign mem_op = load | store;
  lsu_align #(.DATA_W(DATA_W)) u_align (
    .off(ls_addr[OW-1:0]),
    .size(ls_op[1:0]),
    .sign(ls_op[OP_SIGN]),
    .store_data(store_data),
    .rdata(dm_rdata),
    .misaligned(misaligned),
    .wen(wen),
    .wdata(wdata),
    .load_data(load_data)
  );
  always_comb begin
    dm_req = mem_valid & mem_op & ~misaligned & (state == IDLE || state == REQ);
    dm_addr = dm_req ? {ls_addr[ADDR_W-1:OW], OW'(0)} : '0;
    dm_wen = dm_req & store ? wen : '0;
    dm_wdata = dm_req & store ? wdata : '0;
    mem_ade = mem_valid & mem_op & misaligned;
    // non-memory and faulting instructions complete combinationally without leaving IDLE
    mem_over = state == DONE || (state == IDLE && mem_valid && (!mem_op || misaligned));
    mem_result = state == DONE ? res_q : mem_over ? exe_result : '0;
    mem_wdest = mem_valid ? rf_wdest : '0;
    next = state;
    if (dm_req) next = dm_gnt ? (store ? DONE : WAIT) : REQ;
    else if (state == WAIT && dm_rvalid) next = DONE;
    else if (state == DONE && mem_allow_in) next = IDLE;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      res_q <= '0;
    end else begin
      state <= next;
      if (dm_req && dm_gnt && store) res_q <= exe_result;
      else if (state == WAIT && dm_rvalid) res_q <= load_data;
    end
  end
endmodule
